// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised two-read/one-write register array with
// same-cycle write-to-read bypass, a per-register busy scoreboard for
// in-flight multi-cycle producers, a sticky double-issue error flag and a
// debug tap on one fixed register.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int DEBUG_REG  = 30
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    input  logic                  ctrl_issueEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic                  stall,
    output logic                  err_doubleIssue,
    output logic [DATA_WIDTH-1:0] data_debug
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = '0;
    localparam logic [ADDR_WIDTH-1:0] DEBUG_IDX = ADDR_WIDTH'(DEBUG_REG);
    localparam logic ZERO_EN   = (ZERO_REG != 0);
    localparam logic BYPASS_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] reg_array [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_bits;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  err_flag;
    logic                  double_issue;
    logic                  write_valid;
    logic                  issue_valid;
    logic                  zero_a;
    logic                  zero_b;
    logic                  bypass_a;
    logic                  bypass_b;

    // Qualify write/issue strobes: a hard-wired zero register swallows both.
    always_comb begin
        write_valid = ctrl_writeEnable &&
                      !(ZERO_EN && (ctrl_writeReg == ZERO_IDX));
        issue_valid = ctrl_issueEnable &&
                      !(ZERO_EN && (ctrl_issueReg == ZERO_IDX));
    end

    // Next scoreboard state: writeback frees a register, but a same-cycle
    // issue to that register re-claims it because the new producer wins.
    always_comb begin
        busy_next = busy_bits;
        if (write_valid) begin
            busy_next[ctrl_writeReg] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[ctrl_issueReg] = 1'b1;
        end
        double_issue = issue_valid && busy_bits[ctrl_issueReg] &&
                       !(write_valid && (ctrl_writeReg == ctrl_issueReg));
    end

    // Register array storage; reset clears every entry.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_array[i] <= '0;
            end
        end else if (write_valid) begin
            reg_array[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Busy bits and sticky double-issue flag; reset dominates everything.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            busy_bits <= '0;
            err_flag  <= 1'b0;
        end else begin
            busy_bits <= busy_next;
            err_flag  <= err_flag | double_issue;
        end
    end

    // Detect per-port zero-register reads and same-cycle write forwarding.
    always_comb begin
        zero_a   = ZERO_EN && (ctrl_readRegA == ZERO_IDX);
        zero_b   = ZERO_EN && (ctrl_readRegB == ZERO_IDX);
        bypass_a = BYPASS_EN && !ctrl_reset && write_valid &&
                   (ctrl_writeReg == ctrl_readRegA);
        bypass_b = BYPASS_EN && !ctrl_reset && write_valid &&
                   (ctrl_writeReg == ctrl_readRegB);
    end

    // Read port A: zero register, then forwarded write data, then array.
    always_comb begin
        data_readRegA = reg_array[ctrl_readRegA];
        busy_readRegA = busy_bits[ctrl_readRegA];
        if (zero_a) begin
            data_readRegA = '0;
            busy_readRegA = 1'b0;
        end else if (bypass_a) begin
            data_readRegA = data_writeReg;
            busy_readRegA = 1'b0;
        end
    end

    // Read port B resolves independently of port A.
    always_comb begin
        data_readRegB = reg_array[ctrl_readRegB];
        busy_readRegB = busy_bits[ctrl_readRegB];
        if (zero_b) begin
            data_readRegB = '0;
            busy_readRegB = 1'b0;
        end else if (bypass_b) begin
            data_readRegB = data_writeReg;
            busy_readRegB = 1'b0;
        end
    end

    // Decode stalls whenever either operand still has a pending producer.
    always_comb begin
        stall           = busy_readRegA | busy_readRegB;
        err_doubleIssue = err_flag;
        data_debug      = reg_array[DEBUG_IDX];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: drives a BYPASS=1 and a BYPASS=0 instance with the
// same inputs and compares both against one behavioural register/scoreboard
// model every cycle, plus directed scenarios with literal expectations.
module tb_regfile_scoreboard;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;

    logic [31:0] byp_data_a, byp_data_b, byp_debug;
    logic        byp_busy_a, byp_busy_b, byp_stall, byp_err;
    logic [31:0] nob_data_a, nob_data_b, nob_debug;
    logic        nob_busy_a, nob_busy_b, nob_stall, nob_err;

    int checks;
    int errors;
    logic check_en;

    // Behavioural model state
    logic [31:0] mem_m [32];
    logic        busy_m [32];
    logic        err_m;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1),
                         .BYPASS(1), .DEBUG_REG(30)) dut_bypass (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB), .ctrl_issueEnable(ctrl_issueEnable),
        .ctrl_issueReg(ctrl_issueReg), .data_readRegA(byp_data_a),
        .data_readRegB(byp_data_b), .busy_readRegA(byp_busy_a),
        .busy_readRegB(byp_busy_b), .stall(byp_stall),
        .err_doubleIssue(byp_err), .data_debug(byp_debug)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1),
                         .BYPASS(0), .DEBUG_REG(30)) dut_nobypass (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB), .ctrl_issueEnable(ctrl_issueEnable),
        .ctrl_issueReg(ctrl_issueReg), .data_readRegA(nob_data_a),
        .data_readRegB(nob_data_b), .busy_readRegA(nob_busy_a),
        .busy_readRegB(nob_busy_b), .stall(nob_stall),
        .err_doubleIssue(nob_err), .data_debug(nob_debug)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic we,
                                 input logic [4:0] wreg, input logic [31:0] wdata,
                                 input logic [4:0] ra, input logic [4:0] rb,
                                 input logic ie, input logic [4:0] ireg);
        @(posedge clock);
        #1;
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wreg;
        data_writeReg    = wdata;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        ctrl_issueEnable = ie;
        ctrl_issueReg    = ireg;
    endtask

    // What a read port must show: r0 is zero, forwarded data when bypassing
    function automatic logic [31:0] exp_data(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && !ctrl_reset && ctrl_writeEnable && ctrl_writeReg == addr)
            return data_writeReg;
        return mem_m[addr];
    endfunction

    function automatic logic exp_busy(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return 1'b0;
        if (byp && !ctrl_reset && ctrl_writeEnable && ctrl_writeReg == addr)
            return 1'b0;
        return busy_m[addr];
    endfunction

    // Reference model: apply the clock-edge rules to the model arrays
    always @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_m[i]  = 32'h0;
                busy_m[i] = 1'b0;
            end
            err_m = 1'b0;
        end else begin
            if (ctrl_issueEnable && ctrl_issueReg != 5'd0 && busy_m[ctrl_issueReg] &&
                !(ctrl_writeEnable && ctrl_writeReg == ctrl_issueReg))
                err_m = 1'b1;
            if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
                mem_m[ctrl_writeReg]  = data_writeReg;
                busy_m[ctrl_writeReg] = 1'b0;
            end
            if (ctrl_issueEnable && ctrl_issueReg != 5'd0)
                busy_m[ctrl_issueReg] = 1'b1;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("byp_dataA", byp_data_a, exp_data(ctrl_readRegA, 1'b1));
            checkOutput("byp_dataB", byp_data_b, exp_data(ctrl_readRegB, 1'b1));
            checkOutput("byp_busyA", 32'(byp_busy_a), 32'(exp_busy(ctrl_readRegA, 1'b1)));
            checkOutput("byp_busyB", 32'(byp_busy_b), 32'(exp_busy(ctrl_readRegB, 1'b1)));
            checkOutput("byp_stall", 32'(byp_stall),
                        32'(exp_busy(ctrl_readRegA, 1'b1) | exp_busy(ctrl_readRegB, 1'b1)));
            checkOutput("byp_err", 32'(byp_err), 32'(err_m));
            checkOutput("byp_debug", byp_debug, mem_m[30]);
            checkOutput("nob_dataA", nob_data_a, exp_data(ctrl_readRegA, 1'b0));
            checkOutput("nob_dataB", nob_data_b, exp_data(ctrl_readRegB, 1'b0));
            checkOutput("nob_busyA", 32'(nob_busy_a), 32'(exp_busy(ctrl_readRegA, 1'b0)));
            checkOutput("nob_busyB", 32'(nob_busy_b), 32'(exp_busy(ctrl_readRegB, 1'b0)));
            checkOutput("nob_stall", 32'(nob_stall),
                        32'(exp_busy(ctrl_readRegA, 1'b0) | exp_busy(ctrl_readRegB, 1'b0)));
            checkOutput("nob_err", 32'(nob_err), 32'(err_m));
            checkOutput("nob_debug", nob_debug, mem_m[30]);
        end
    end

    // Directed scenarios with literal expectations, then random traffic
    initial begin
        checks = 0;
        errors = 0;
        check_en = 1'b0;
        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = '0;
        data_writeReg = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        ctrl_issueEnable = 1'b0;
        ctrl_issueReg = '0;

        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        check_en = 1'b1;
        $display("[TB] reset sweep");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
            @(negedge clock);
            checkOutput("rst_dataA", byp_data_a, 32'h0);
            checkOutput("rst_dataB", nob_data_b, 32'h0);
            checkOutput("rst_stall", 32'(byp_stall | nob_stall), 32'h0);
            checkOutput("rst_err", 32'(byp_err | nob_err), 32'h0);
        end

        $display("[TB] write r5 with bypass / without bypass");
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("byp_w5_same", byp_data_a, 32'hDEADBEEF);
        checkOutput("nob_w5_same", nob_data_a, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("byp_w5_next", byp_data_a, 32'hDEADBEEF);
        checkOutput("nob_w5_next", nob_data_a, 32'hDEADBEEF);

        $display("[TB] issue r7 then writeback");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("r7_busy", 32'(byp_busy_b), 32'h1);
        checkOutput("r7_stall", 32'(byp_stall), 32'h1);
        checkOutput("r7_busy_nob", 32'(nob_busy_b), 32'h1);
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd7, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("r7_wb_busy", 32'(byp_busy_b), 32'h0);
        checkOutput("r7_wb_stall", 32'(byp_stall), 32'h0);
        checkOutput("r7_wb_data", byp_data_b, 32'h12345678);
        checkOutput("r7_wb_busy_nob", 32'(nob_busy_b), 32'h1);
        checkOutput("r7_wb_data_nob", nob_data_b, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("r7_after_nob", nob_data_b, 32'h12345678);
        checkOutput("r7_after_busy_nob", 32'(nob_busy_b), 32'h0);

        $display("[TB] zero register");
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        @(negedge clock);
        checkOutput("r0_same", byp_data_a, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("r0_data", byp_data_a, 32'h0);
        checkOutput("r0_busy", 32'(byp_busy_b), 32'h0);
        checkOutput("r0_err", 32'(byp_err), 32'h0);

        $display("[TB] r9 issue / write+issue / double issue");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hAA, 5'd0, 5'd9, 1'b1, 5'd9);
        @(negedge clock);
        checkOutput("r9_wi_busy", 32'(byp_busy_b), 32'h0);
        checkOutput("r9_wi_busy_nob", 32'(nob_busy_b), 32'h1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("r9_busy_after", 32'(byp_busy_b), 32'h1);
        checkOutput("r9_noerr", 32'(byp_err), 32'h0);
        checkOutput("r9_data", nob_data_b, 32'hAA);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("r9_err", 32'(byp_err), 32'h1);
        checkOutput("r9_err_nob", 32'(nob_err), 32'h1);

        $display("[TB] debug tap and mid-flight reset");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3);
        applyStimulus(1'b0, 1'b1, 5'd30, 32'h55, 5'd0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("dbg_55", byp_debug, 32'h55);
        checkOutput("r3_busy_pre", 32'(byp_busy_b), 32'h1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("dbg_cleared", byp_debug, 32'h0);
        checkOutput("r3_busy_post", 32'(byp_busy_b), 32'h0);
        checkOutput("err_cleared", 32'(byp_err), 32'h0);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h77, 5'd0, 5'd3, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0);
        @(negedge clock);
        checkOutput("late_wb_data", nob_data_b, 32'h77);
        checkOutput("late_wb_err", 32'(nob_err), 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            logic rst, we, ie;
            logic [4:0] wreg, ra, rb, ireg;
            logic [31:0] wdata;
            rst   = ($urandom_range(0, 99) == 0);
            we    = !rst && ($urandom_range(0, 1) == 1);
            wreg  = 5'($urandom_range(0, 31));
            wdata = $urandom;
            ie    = ($urandom_range(0, 3) == 0);
            ireg  = 5'($urandom_range(0, 31));
            ra    = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
            rb    = ($urandom_range(0, 3) == 0) ? ireg : 5'($urandom_range(0, 31));
            applyStimulus(rst, we, wreg, wdata, ra, rb, ie, ireg);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
